// File: rtl/goomba_collision_judge.sv
// Collision judge between Mario and one Goomba: decides stomp vs. side hit on each
// frame tick, runs the Goomba's ALIVE/SQUASHED/GONE lifecycle and keeps a stomp score.
module goomba_collision_judge #(
    parameter int CHARACTER_WIDTH = 42,
    parameter int STOMP_MARGIN    = 12,
    parameter int SQUASH_FRAMES   = 30
) (
    input  logic               vga_clock,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic signed [31:0] mario_x,
    input  logic signed [31:0] mario_y,
    input  logic signed [31:0] goomba_x,
    input  logic signed [31:0] goomba_y,
    output logic               lose,
    output logic               stomp,
    output logic               goomba_visible,
    output logic               goomba_squashed,
    output logic [15:0]        score
);

    // A zero (or negative) squash length still shows the squashed sprite for one tick.
    localparam int SQ_LOAD = (SQUASH_FRAMES < 1) ? 1 : SQUASH_FRAMES;
    localparam int CNT_W   = $clog2(SQ_LOAD + 1);

    typedef enum logic [1:0] {
        ST_ALIVE    = 2'd0,
        ST_SQUASHED = 2'd1,
        ST_GONE     = 2'd2
    } state_t;

    function automatic logic signed [31:0] abs32(input logic signed [31:0] v);
        abs32 = (v < 32'sd0) ? -v : v;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lose_q, lose_d;
    logic               stomp_q, stomp_d;
    logic               visible_q, visible_d;
    logic               squashed_q, squashed_d;
    logic [15:0]        score_q, score_d;

    logic signed [31:0] dx_s, dy_s, rel_s;
    logic               overlap_s, stomp_hit_s, side_hit_s;

    // Geometry: box overlap, and how far Mario's feet sink below the Goomba's top edge.
    always_comb begin
        dx_s        = mario_x - goomba_x;
        dy_s        = mario_y - goomba_y;
        rel_s       = mario_y + CHARACTER_WIDTH - goomba_y;
        overlap_s   = (abs32(dx_s) < CHARACTER_WIDTH) && (abs32(dy_s) < CHARACTER_WIDTH);
        stomp_hit_s = overlap_s && (rel_s <= STOMP_MARGIN);
        side_hit_s  = overlap_s && !stomp_hit_s;
    end

    // Next-state logic; a latched lose freezes everything except reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lose_d  = lose_q;
        stomp_d = 1'b0;
        score_d = score_q;
        if (frame_tick && !lose_q) begin
            case (state_q)
                ST_ALIVE: begin
                    if (stomp_hit_s) begin
                        state_d = ST_SQUASHED;
                        cnt_d   = CNT_W'(SQ_LOAD);
                        stomp_d = 1'b1;
                        score_d = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
                    end else if (side_hit_s) begin
                        lose_d = 1'b1;
                    end else begin
                        lose_d = lose_q;
                    end
                end
                ST_SQUASHED: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_GONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_GONE: begin
                    state_d = ST_GONE;
                end
                default: begin
                    state_d = ST_ALIVE;
                    cnt_d   = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        visible_d  = (state_d != ST_GONE);
        squashed_d = (state_d == ST_SQUASHED);
    end

    // State and registered outputs.
    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_ALIVE;
            cnt_q      <= '0;
            lose_q     <= 1'b0;
            stomp_q    <= 1'b0;
            visible_q  <= 1'b1;
            squashed_q <= 1'b0;
            score_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lose_q     <= lose_d;
            stomp_q    <= stomp_d;
            visible_q  <= visible_d;
            squashed_q <= squashed_d;
            score_q    <= score_d;
        end
    end

    assign lose            = lose_q;
    assign stomp           = stomp_q;
    assign goomba_visible  = visible_q;
    assign goomba_squashed = squashed_q;
    assign score           = score_q;

endmodule

// File: tb/tb_goomba_collision_judge.sv
// Bench for goomba_collision_judge: directed scenarios plus random play against a
// small game-rule model.
module tb_goomba_collision_judge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ft = 1'b0;
    logic signed [31:0] mx = 32'sd0, my = 32'sd0, gx = 32'sd500, gy = 32'sd500;
    logic        lose, stomp, vis, sq;
    logic [15:0] score;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: game-level view of the Goomba
    bit m_alive, m_lose, m_stomp;
    int m_sq_left, m_score;

    goomba_collision_judge dut (
        .vga_clock(clk), .reset(reset), .frame_tick(ft),
        .mario_x(mx), .mario_y(my), .goomba_x(gx), .goomba_y(gy),
        .lose(lose), .stomp(stomp), .goomba_visible(vis),
        .goomba_squashed(sq), .score(score)
    );

    always #5 clk = ~clk;

    wire [19:0] act_v = {lose, stomp, vis, sq, score};
    localparam logic [19:0] RESET_V = {1'b0, 1'b0, 1'b1, 1'b0, 16'd0};

    function automatic logic [19:0] exp_v();
        bit v, s;
        v = m_alive || (m_sq_left > 0);
        s = !m_alive && (m_sq_left > 0);
        return {m_lose, m_stomp, v, s, 16'(m_score)};
    endfunction

    function automatic string fmt(input logic [19:0] v);
        return $sformatf("lose=%0b stomp=%0b vis=%0b sq=%0b score=%0d",
                         v[19], v[18], v[17], v[16], v[15:0]);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        m_alive = 1; m_lose = 0; m_stomp = 0; m_sq_left = 0; m_score = 0;
    endtask

    task automatic model_step(input bit t, input int ax, input int ay, input int bx, input int by);
        bit hit;
        hit = (iabs(ax - bx) < 42) && (iabs(ay - by) < 42);
        m_stomp = 0;
        if (t && !m_lose) begin
            if (m_alive) begin
                if (hit && (ay + 42 - by <= 12)) begin
                    m_alive = 0;
                    m_sq_left = 30;
                    m_stomp = 1;
                    if (m_score < 65535) m_score++;
                end else if (hit) begin
                    m_lose = 1;
                end
            end else if (m_sq_left > 0) begin
                m_sq_left--;
            end
        end
    endtask

    task automatic drive_cycle(input bit t, input int ax, input int ay, input int bx, input int by);
        ft = t; mx = ax; my = ay; gx = bx; gy = by;
        @(posedge clk); #1;
        model_step(t, ax, ay, bx, by);
    endtask

    task automatic do_reset();
        reset = 1'b1; ft = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (act_v !== RESET_V) begin
            n_bad++;
            $display("FAIL reset: got %s want %s", fmt(act_v), fmt(RESET_V));
        end
    endtask

    task automatic test_side_hit();
        logic [19:0] want;
        do_reset();
        drive_cycle(1, 100, 360, 130, 360);
        want = {1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
        n_cmp++;
        if (act_v !== want) begin
            n_bad++;
            $display("FAIL side_hit: got %s want %s", fmt(act_v), fmt(want));
        end
        drive_cycle(0, 100, 360, 130, 360);
        n_cmp++;
        if (act_v !== want) begin
            n_bad++;
            $display("FAIL side_hit_sticky: got %s want %s", fmt(act_v), fmt(want));
        end
    endtask

    task automatic test_stomp_expiry();
        logic [19:0] want;
        do_reset();
        drive_cycle(1, 100, 320, 110, 360);
        want = {1'b0, 1'b1, 1'b1, 1'b1, 16'd1};
        n_cmp++;
        if (act_v !== want) begin
            n_bad++;
            $display("FAIL stomp: got %s want %s", fmt(act_v), fmt(want));
        end
        drive_cycle(0, 100, 320, 110, 360);
        want = {1'b0, 1'b0, 1'b1, 1'b1, 16'd1};
        n_cmp++;
        if (act_v !== want) begin
            n_bad++;
            $display("FAIL stomp_one_cycle: got %s want %s", fmt(act_v), fmt(want));
        end
        for (int i = 1; i <= 29; i++) drive_cycle(1, 100, 360, 110, 360);
        n_cmp++;
        if (act_v !== want) begin
            n_bad++;
            $display("FAIL squash_29_ticks: got %s want %s", fmt(act_v), fmt(want));
        end
        drive_cycle(1, 100, 360, 110, 360);
        want = {1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        n_cmp++;
        if (act_v !== want) begin
            n_bad++;
            $display("FAIL squash_30_ticks: got %s want %s", fmt(act_v), fmt(want));
        end
        drive_cycle(1, 100, 360, 130, 360);
        drive_cycle(1, 100, 320, 110, 360);
        n_cmp++;
        if (act_v !== want) begin
            n_bad++;
            $display("FAIL gone_ignores_hits: got %s want %s", fmt(act_v), fmt(want));
        end
    endtask

    task automatic test_overlap_edges();
        int ex[4] = '{142, 58, 100, 100};
        int ey[4] = '{360, 360, 318, 402};
        logic [19:0] want;
        for (int i = 0; i < 4; i++) begin
            do_reset();
            drive_cycle(1, 100, ey[i], ex[i], 360);
            n_cmp++;
            if (act_v !== RESET_V) begin
                n_bad++;
                $display("FAIL edge_no_overlap[%0d]: got %s want %s", i, fmt(act_v), fmt(RESET_V));
            end
        end
        do_reset();
        drive_cycle(1, 100, 360, 141, 360);
        want = {1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
        n_cmp++;
        if (act_v !== want) begin
            n_bad++;
            $display("FAIL edge_dx41: got %s want %s", fmt(act_v), fmt(want));
        end
    endtask

    task automatic test_gating();
        logic [19:0] want;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            drive_cycle(0, 100, 360, 130, 360);
            n_cmp++;
            if (act_v !== RESET_V) begin
                n_bad++;
                $display("FAIL gating_idle[%0d]: got %s want %s", i, fmt(act_v), fmt(RESET_V));
            end
        end
        drive_cycle(1, 100, 360, 130, 360);
        drive_cycle(1, 100, 320, 110, 360);
        want = {1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
        n_cmp++;
        if (act_v !== want) begin
            n_bad++;
            $display("FAIL gating_after_lose: got %s want %s", fmt(act_v), fmt(want));
        end
    endtask

    task automatic test_reset_mid_squash();
        logic [19:0] want;
        do_reset();
        drive_cycle(1, 100, 320, 110, 360);
        for (int i = 0; i < 15; i++) drive_cycle(1, 0, 0, 500, 500);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (act_v !== RESET_V) begin
            n_bad++;
            $display("FAIL reset_async: got %s want %s", fmt(act_v), fmt(RESET_V));
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        drive_cycle(0, 100, 320, 110, 360);
        n_cmp++;
        if (act_v !== RESET_V) begin
            n_bad++;
            $display("FAIL reset_no_residue: got %s want %s", fmt(act_v), fmt(RESET_V));
        end
        drive_cycle(1, 100, 320, 110, 360);
        want = {1'b0, 1'b1, 1'b1, 1'b1, 16'd1};
        n_cmp++;
        if (act_v !== want) begin
            n_bad++;
            $display("FAIL first_tick_after_reset: got %s want %s", fmt(act_v), fmt(want));
        end
    endtask

    task automatic test_random();
        int bx, by, ax, ay;
        for (int r = 0; r < 40; r++) begin
            do_reset();
            for (int c = 0; c < 80; c++) begin
                bx = int'($urandom_range(100, 400));
                by = int'($urandom_range(100, 400));
                ax = bx + int'($urandom_range(0, 100)) - 50;
                if ($urandom_range(0, 2) == 0) ay = by - 42 + int'($urandom_range(0, 16));
                else ay = by + int'($urandom_range(0, 100)) - 50;
                if ($urandom_range(0, 3) != 0) begin
                    ax = ax + 200;
                end
                drive_cycle($urandom_range(0, 2) == 0, ax, ay, bx, by);
                n_cmp++;
                if (act_v !== exp_v()) begin
                    n_bad++;
                    $display("FAIL random[%0d.%0d]: got %s want %s", r, c, fmt(act_v), fmt(exp_v()));
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_side_hit();
        test_stomp_expiry();
        test_overlap_edges();
        test_gating();
        test_reset_mid_squash();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/goomba_collision_judge.md
GOOMBA_COLLISION_JUDGE -- requirements
Module: goomba_collision_judge

Interface
REQ-001 SHALL have parameter CHARACTER_WIDTH, default 42, sprite edge length in pixels for both characters.
REQ-002 SHALL have parameter STOMP_MARGIN, default 12, pixel band below the Goomba's top edge that counts as a stomp.
REQ-003 SHALL have parameter SQUASH_FRAMES, default 30, frame_tick count the squashed sprite stays visible.
REQ-004 SHALL have port vga_clock  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port frame_tick  input  1  one-cycle strobe; collision is evaluated only on cycles where it is high.
REQ-007 SHALL have port mario_x, mario_y  input  int (32, signed)  Mario top-left pixel.
REQ-008 SHALL have port goomba_x, goomba_y  input  int (32, signed)  Goomba top-left pixel, from the Goomba mover.
REQ-009 SHALL have port lose  output  1  sticky; Mario was hit from the side or below.
REQ-010 SHALL have port stomp  output  1  one-cycle pulse on a successful stomp.
REQ-011 SHALL have port goomba_visible  output  1  Goomba sprite is drawn.
REQ-012 SHALL have port goomba_squashed  output  1  draw squashed sprite instead of walking sprite.
REQ-013 SHALL have port score  output  16  saturating stomp count.

Function
REQ-014 SHALL keep Goomba state machine ALIVE, SQUASHED, GONE, and a 1-bit lose latch.
REQ-015 SHALL define overlap as |mario_x-goomba_x| < CHARACTER_WIDTH AND |mario_y-goomba_y| < CHARACTER_WIDTH, computed in 32-bit signed arithmetic.
REQ-016 SHALL define stomp_hit as overlap AND (mario_y + CHARACTER_WIDTH - goomba_y) <= STOMP_MARGIN.
REQ-017 SHALL define side_hit as overlap AND NOT stomp_hit.
REQ-018 SHALL evaluate only when frame_tick=1, state=ALIVE and lose=0; no evaluation in any other cycle.
REQ-019 On evaluation with stomp_hit: SHALL move ALIVE->SQUASHED, load squash counter with SQUASH_FRAMES, pulse stomp for exactly the next cycle, increment score by 1.
REQ-020 On evaluation with side_hit: SHALL set lose=1 at the next edge; state stays ALIVE; stomp stays 0.
REQ-021 stomp_hit and side_hit are mutually exclusive by definition; stomp takes priority.
REQ-022 In SQUASHED: SHALL decrement squash counter on each frame_tick; on the frame_tick where counter is 1, move to GONE; no collision checked.
REQ-023 In GONE: SHALL remain until reset; no collision, no score change.
REQ-024 lose, once 1, SHALL hold until reset and freeze state machine, squash counter and score.
REQ-025 goomba_visible SHALL be 1 in ALIVE and SQUASHED, 0 in GONE; goomba_squashed SHALL be 1 only in SQUASHED.
REQ-026 score SHALL saturate at 16'hFFFF; stomp still pulses at saturation.
REQ-027 All outputs SHALL be registered; latency from evaluating frame_tick edge to lose/stomp/state change is one vga_clock cycle.
REQ-028 SQUASH_FRAMES=0 SHALL be treated as 1.

Reset
REQ-029 On reset=1, asynchronously: state=ALIVE, lose=0, stomp=0, score=0, squash counter=0, goomba_visible=1, goomba_squashed=0.
REQ-030 Reset asserted mid-SQUASHED or after lose SHALL return to the values of REQ-029 with no residual pulse after release.
REQ-031 After reset deasserts, first evaluation SHALL occur on the first frame_tick sampled high.

Verification
REQ-032 Side hit: mario=(100,360), goomba=(130,360), frame_tick -> next cycle lose=1, stomp=0, score=0, goomba_visible=1.
REQ-033 Stomp: mario=(100,320), goomba=(110,360) (overlap 2 <= 12), frame_tick -> stomp high 1 cycle, score=1, goomba_squashed=1.
REQ-034 Squash expiry: after REQ-033, 30 frame_ticks -> goomba_visible=0 after 30th; 29 ticks -> still squashed; overlap in GONE -> lose stays 0.
REQ-035 Edge of overlap: |dx|=42 or |dy|=42 with frame_tick -> no lose, no stomp; dx=41, dy=0 -> lose=1.
REQ-036 Gating: overlap held with frame_tick=0 for 100 cycles -> no output change; after lose=1, stomp geometry + frame_tick -> score unchanged.
REQ-037 Reset mid-operation: reset pulsed during SQUASHED with counter=15 -> immediately ALIVE, score=0, goomba_squashed=0, stomp=0.
